// File: rtl/seq_detect_sched_if.sv
// Bundle of requester, detector and response signals for seq_detect_sched.
// rsp_first exists only when SEQ_SCHED_FIRST_POS_EN is defined.
interface seq_detect_sched_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 4
);
    localparam int IDW = $clog2(N);
    localparam int FPW = $clog2(W + 1);

    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           det_inp_bit;
    logic           det_reset;
    logic           det_seq_seen;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [CW-1:0]  rsp_count;
    logic           busy;
`ifdef SEQ_SCHED_FIRST_POS_EN
    logic [FPW-1:0] rsp_first;
`endif

    modport slave (
        input  req, req_data, det_seq_seen, rsp_ready,
        output gnt, det_inp_bit, det_reset, rsp_valid, rsp_id, rsp_count, busy
`ifdef SEQ_SCHED_FIRST_POS_EN
        , output rsp_first
`endif
    );

    modport master (
        output req, req_data, det_seq_seen, rsp_ready,
        input  gnt, det_inp_bit, det_reset, rsp_valid, rsp_id, rsp_count, busy
`ifdef SEQ_SCHED_FIRST_POS_EN
        , input rsp_first
`endif
    );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one external 1011 detector between N requesters.
// Optional SEQ_SCHED_FIRST_POS_EN adds rsp_first (bit index of the first match).

module seq_detect_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           vld_o,
    output logic [IDW-1:0] idx_o
);
    logic           hi_found, lo_found;
    logic [IDW-1:0] hi_idx, lo_idx;

    // Downward scan leaves the lowest index above ptr (hi) and the lowest at/below it (lo).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (IDW'(i) > ptr_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        vld_o = hi_found | lo_found;
        idx_o = hi_found ? hi_idx : lo_idx;
    end
endmodule

module seq_detect_sched #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    seq_detect_sched_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int BW  = $clog2(W);
    localparam int FPW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   word_q, word_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
`ifdef SEQ_SCHED_FIRST_POS_EN
    logic [FPW-1:0] first_q, first_d;
`endif

    logic [N-1:0][W-1:0] words;
    logic                arb_vld;
    logic [IDW-1:0]      arb_idx;
    logic [N-1:0]        gnt;
    logic                det_reset, det_inp_bit, rsp_valid, sampling;

    assign words = bus.req_data;

    seq_detect_rr_arb #(.N(N), .IDW(IDW)) u_arb (
        .req_i (bus.req),
        .ptr_i (rr_q),
        .vld_o (arb_vld),
        .idx_o (arb_idx)
    );

    assign sampling = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bit_d       = bit_q;
        rr_d        = rr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
`ifdef SEQ_SCHED_FIRST_POS_EN
        first_d     = first_q;
`endif
        gnt         = '0;
        det_reset   = 1'b0;
        det_inp_bit = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                det_reset = 1'b1;
                if (arb_vld) begin
                    gnt[arb_idx] = 1'b1;
                    word_d       = words[arb_idx];
                    rr_d         = arb_idx;
                    id_d         = arb_idx;
                    cnt_d        = '0;
                    bit_d        = '0;
`ifdef SEQ_SCHED_FIRST_POS_EN
                    first_d      = FPW'(W);
`endif
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // MSB-first: the word shifts left and the top bit feeds the detector.
                det_inp_bit = word_q[W-1];
                word_d      = {word_q[W-2:0], 1'b0};
                bit_d       = bit_q + 1'b1;
                if (bit_q == BW'(W - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                det_reset = 1'b1;
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // seq_seen lags the input by one cycle, so sample k reports bit k-1.
        if (sampling && bus.det_seq_seen) begin
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
`ifdef SEQ_SCHED_FIRST_POS_EN
            if (first_q == FPW'(W)) begin
                if (state_q == ST_DRAIN)  first_d = FPW'(W - 1);
                else if (bit_q != '0)     first_d = FPW'(bit_q) - FPW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            rr_q    <= IDW'(N - 1);
            id_q    <= '0;
            cnt_q   <= '0;
`ifdef SEQ_SCHED_FIRST_POS_EN
            first_q <= FPW'(W);
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_SCHED_FIRST_POS_EN
            first_q <= first_d;
`endif
        end
    end

    assign bus.gnt         = gnt;
    assign bus.det_inp_bit = det_inp_bit;
    assign bus.det_reset   = det_reset;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_count   = cnt_q;
    assign bus.busy        = (state_q != ST_IDLE);
`ifdef SEQ_SCHED_FIRST_POS_EN
    assign bus.rsp_first   = first_q;
`endif
endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched (N=4, W=8) with a behavioural 1011 detector,
// plus a CW=1 instance for counter saturation.
module tb_seq_detect_sched;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_detect_sched_if #(.N(4), .W(8), .CW(4)) if0 ();
    seq_detect_sched_if #(.N(4), .W(8), .CW(1)) if1 ();

    seq_detect_sched #(.N(4), .W(8), .CW(4)) u_dut (.clk(clk), .reset_n(reset_n), .bus(if0));
    seq_detect_sched #(.N(4), .W(8), .CW(1)) u_sat (.clk(clk), .reset_n(reset_n), .bus(if1));

    // 0:IDLE 1:S1 2:S10 3:S101 4:S1011 (seen); after a match 1->S1, 0->IDLE
    function automatic logic [2:0] det_nxt(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    det_nxt = b ? 3'd1 : 3'd0;
            3'd1:    det_nxt = b ? 3'd1 : 3'd2;
            3'd2:    det_nxt = b ? 3'd3 : 3'd0;
            3'd3:    det_nxt = b ? 3'd4 : 3'd2;
            default: det_nxt = b ? 3'd1 : 3'd0;
        endcase
    endfunction

    logic [2:0] det0_q = 3'd0;
    logic [2:0] det1_q = 3'd0;
    always_ff @(posedge clk) det0_q <= if0.det_reset ? 3'd0 : det_nxt(det0_q, if0.det_inp_bit);
    always_ff @(posedge clk) det1_q <= if1.det_reset ? 3'd0 : det_nxt(det1_q, if1.det_inp_bit);
    assign if0.det_seq_seen = (det0_q == 3'd4);
    assign if1.det_seq_seen = (det1_q == 3'd4);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(input string tag);
        int c = 0;
        while (if0.gnt == '0 && c < 40) begin
            @(posedge clk); #1; c++;
        end
        chk(tag, {31'd0, if0.gnt != '0}, 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int c = 0;
        while (!if0.rsp_valid && c < 40) begin
            @(posedge clk); #1; c++;
        end
        chk(tag, {31'd0, if0.rsp_valid}, 32'd1);
    endtask

    // Entered and left at posedge+1 in IDLE with rsp_ready=1.
    task automatic run_word(input int id, input logic [7:0] data, input int cnt, input int first);
        if0.req_data[id*8 +: 8] = data;
        if0.req[id] = 1'b1;
        #1;
        wait_gnt("w_gnt_seen");
        chk("w_gnt_vec", if0.gnt, 32'd1 << id);
        chk("w_idle_busy", if0.busy, 0);
        @(posedge clk); #1;
        if0.req[id] = 1'b0;
        chk("w_shift_detrst", if0.det_reset, 0);
        for (int k = 0; k < 8; k++) begin
            chk("w_bit", if0.det_inp_bit, data[7-k]);
            @(posedge clk); #1;
        end
        chk("w_drain_vld", if0.rsp_valid, 0);
        @(posedge clk); #1;
        chk("w_rsp_vld_at_10", if0.rsp_valid, 1);
        chk("w_rsp_id", if0.rsp_id, id);
        chk("w_rsp_cnt", if0.rsp_count, cnt);
        chk("w_resp_detrst", if0.det_reset, 1);
`ifdef SEQ_SCHED_FIRST_POS_EN
        chk("w_rsp_first", if0.rsp_first, first);
`endif
        @(posedge clk); #1;
        chk("w_rsp_drop", if0.rsp_valid, 0);
    endtask

    logic [3:0] exp_cnt [4] = '{4'd2, 4'd1, 4'd0, 4'd1};

    initial begin
        if0.req = '0; if0.req_data = '0; if0.rsp_ready = 1'b1;
        if1.req = '0; if1.req_data = '0; if1.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", if0.gnt, 0);
        chk("rst_inp", if0.det_inp_bit, 0);
        chk("rst_detrst", if0.det_reset, 1);
        chk("rst_vld", if0.rsp_valid, 0);
        chk("rst_id", if0.rsp_id, 0);
        chk("rst_cnt", if0.rsp_count, 0);
        chk("rst_busy", if0.busy, 0);
`ifdef SEQ_SCHED_FIRST_POS_EN
        chk("rst_first", if0.rsp_first, 8);
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_word(0, 8'hBB, 2, 3);
        run_word(1, 8'hB0, 1, 3);
        run_word(2, 8'h00, 0, 8);
        run_word(3, 8'hFF, 0, 8);
        run_word(0, 8'h2D, 1, 5);

        // Fairness from a fresh pointer
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        if0.req_data = {8'h2D, 8'h00, 8'hB0, 8'hBB};
        if0.req = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt("rr_gnt_seen");
            chk("rr_gnt_vec", if0.gnt, 32'd1 << (g % 4));
            @(posedge clk); #1;
            if (g == 4) if0.req = '0;
            wait_rsp("rr_rsp_seen");
            chk("rr_rsp_id", if0.rsp_id, g % 4);
            chk("rr_rsp_cnt", if0.rsp_count, exp_cnt[g % 4]);
            @(posedge clk); #1;
        end

        // Backpressure, with another requester waiting
        if0.rsp_ready = 1'b0;
        if0.req_data[15:8] = 8'hB0;
        if0.req[1] = 1'b1;
        #1;
        wait_gnt("bp_gnt_seen");
        chk("bp_gnt_vec", if0.gnt, 4'b0010);
        @(posedge clk); #1;
        if0.req[1] = 1'b0;
        if0.req_data[23:16] = 8'h00;
        if0.req[2] = 1'b1;
        wait_rsp("bp_rsp_seen");
        for (int c = 0; c < 5; c++) begin
            chk("bp_vld", if0.rsp_valid, 1);
            chk("bp_id", if0.rsp_id, 1);
            chk("bp_cnt", if0.rsp_count, 1);
            chk("bp_busy", if0.busy, 1);
            chk("bp_no_gnt", if0.gnt, 0);
            @(posedge clk); #1;
        end
        if0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_vld", if0.rsp_valid, 0);
        chk("bp_rel_busy", if0.busy, 0);
        chk("bp_rel_gnt", if0.gnt, 4'b0100);
        @(posedge clk); #1;
        if0.req[2] = 1'b0;
        wait_rsp("bp2_rsp_seen");
        chk("bp2_id", if0.rsp_id, 2);
        chk("bp2_cnt", if0.rsp_count, 0);
        @(posedge clk); #1;

        // Async reset in SHIFT cycle 3
        if0.req_data[7:0] = 8'hBB;
        if0.req[0] = 1'b1;
        #1;
        wait_gnt("ar_gnt_seen");
        @(posedge clk); #1;
        if0.req[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("ar_pre_bit", if0.det_inp_bit, 1);
        chk("ar_pre_busy", if0.busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_detrst", if0.det_reset, 1);
        chk("ar_busy", if0.busy, 0);
        chk("ar_inp", if0.det_inp_bit, 0);
        chk("ar_cnt", if0.rsp_count, 0);
        chk("ar_id", if0.rsp_id, 0);
        chk("ar_vld", if0.rsp_valid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 15; c++) begin
                if (if0.rsp_valid || if0.busy) seen++;
                @(posedge clk); #1;
            end
            chk("ar_no_rsp", seen, 0);
        end
        run_word(0, 8'hBB, 2, 3);

        // Saturation on the CW=1 instance
        begin
            int c = 0;
            if1.req_data[7:0] = 8'hBB;
            if1.req[0] = 1'b1;
            #1;
            while (if1.gnt == '0 && c < 40) begin
                @(posedge clk); #1; c++;
            end
            chk("sat_gnt", if1.gnt, 4'b0001);
            @(posedge clk); #1;
            if1.req[0] = 1'b0;
            c = 0;
            while (!if1.rsp_valid && c < 40) begin
                @(posedge clk); #1; c++;
            end
            chk("sat_vld", if1.rsp_valid, 1);
            chk("sat_cnt", if1.rsp_count, 1);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
